// File: rtl/adapter_1_to_4_pkg.sv
// Shared constants and state encoding for the 1-to-4 unpacking adapter.
// Default widths match adapter_4_to_1 so that both ends agree on lane order.
package adapter_1_to_4_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned N_OUTPUTS_DEF  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Lane index width, never narrower than one bit.
  function automatic int unsigned lane_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adapter_1_to_4_slice_select.sv
// Combinational N_OUTPUTS:1 mux picking one DATA_WIDTH slice out of a packed word.
// Lane 0 is the least-significant slice.
module slice_select
  import adapter_1_to_4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned N_OUTPUTS  = N_OUTPUTS_DEF,
  parameter int unsigned LANE_W     = lane_width(N_OUTPUTS_DEF)
) (
  input  logic [N_OUTPUTS*DATA_WIDTH-1:0] word,
  input  logic [LANE_W-1:0]               lane,
  output logic [DATA_WIDTH-1:0]           slice_c
);

  always_comb begin
    slice_c = '0;
    for (int unsigned i = 0; i < N_OUTPUTS; i++) begin
      if (lane == LANE_W'(i)) slice_c = word[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/adapter_1_to_4.sv
// Unpacks one N_OUTPUTS*DATA_WIDTH word per handshake into per-cycle slices, lane 0 first.
// Define ADAPTER_1_TO_4_BACK2BACK_EN to accept the next word on the last-slice handshake.
module adapter_1_to_4
  import adapter_1_to_4_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int unsigned N_OUTPUTS  = N_OUTPUTS_DEF,
  localparam int unsigned LANE_W     = lane_width(N_OUTPUTS),
  localparam int unsigned WORD_W     = N_OUTPUTS * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [WORD_W-1:0]     r,
  input  logic                  r_valid,
  output logic                  r_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [LANE_W-1:0]     lane_out,
  output logic                  last_out
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_OUTPUTS - 1);

  state_t                  state, state_n;
  logic [WORD_W-1:0]       word, word_n;
  logic [LANE_W-1:0]       lane_n;
  logic                    valid_n;
  logic                    last_n;
  logic [DATA_WIDTH-1:0]   slice_c;
  logic                    accept_c;

  // Held low during reset so nothing is taken while the block is being cleared.
`ifdef ADAPTER_1_TO_4_BACK2BACK_EN
  assign r_ready = reset_L && ((state == ST_IDLE) || (last_out && ready_in));
`else
  assign r_ready = reset_L && (state == ST_IDLE);
`endif

  assign accept_c = r_valid && r_ready;

  always_comb begin
    state_n = state;
    word_n  = word;
    lane_n  = lane_out;
    valid_n = valid_out;
    case (state)
      ST_IDLE: begin
        valid_n = 1'b0;
        lane_n  = '0;
        if (accept_c) begin
          word_n  = r;
          state_n = ST_SEND;
          valid_n = 1'b1;
        end
      end
      ST_SEND: begin
        if (ready_in) begin
          if (lane_out == LAST_LANE) begin
            lane_n = '0;
`ifdef ADAPTER_1_TO_4_BACK2BACK_EN
            if (accept_c) begin
              word_n = r;
            end else begin
              state_n = ST_IDLE;
              valid_n = 1'b0;
            end
`else
            state_n = ST_IDLE;
            valid_n = 1'b0;
`endif
          end else begin
            lane_n = lane_out + LANE_W'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
        lane_n  = '0;
      end
    endcase
    last_n = valid_n && (lane_n == LAST_LANE);
  end

  // Next slice is selected from the next word/lane so data_out can be registered.
  slice_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_OUTPUTS  (N_OUTPUTS),
    .LANE_W     (LANE_W)
  ) u_slice_select (
    .word    (word_n),
    .lane    (lane_n),
    .slice_c (slice_c)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= ST_IDLE;
      word      <= '0;
      lane_out  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      state     <= state_n;
      word      <= word_n;
      lane_out  <= lane_n;
      data_out  <= valid_n ? slice_c : '0;
      valid_out <= valid_n;
      last_out  <= last_n;
    end
  end

endmodule

// File: tb/tb_adapter_1_to_4.sv
// Self-checking bench for adapter_1_to_4: table of words with stall patterns plus
// streaming, mid-word input change and mid-word reset sequences.
module tb_adapter_1_to_4;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  lane;
    logic        last;
  } exp_t;

  typedef struct {
    logic [63:0]      word;
    logic [3:0][15:0] exp;
    int               stall_lane;
    int               stall_len;
  } vec_t;

`ifdef ADAPTER_1_TO_4_BACK2BACK_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 1;
`endif

  logic        clk;
  logic        reset_L;
  logic [63:0] r;
  logic        r_valid;
  logic        r_ready;
  logic [15:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic [1:0]  lane_out;
  logic        last_out;

  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  int   stall_lane;
  int   stall_len;
  bit   in_stream;
  int   gap_cnt;
  bit   seen_v;
  vec_t vecs[6];

  adapter_1_to_4 dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .r         (r),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .lane_out  (lane_out),
    .last_out  (last_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_word(input logic [3:0][15:0] e);
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{data: e[i], lane: 2'(i), last: (i == 3)});
    end
  endtask

  // Drive a word and record its expected slices on the cycle it is accepted.
  task automatic send_word(input logic [63:0] w, input logic [3:0][15:0] e, input bit keep);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    r       = w;
    r_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      #3;
      if (r_ready) begin
        push_word(e);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_timeout", 64'(ok), 64'd1);
    if (!keep) begin
      @(negedge clk);
      r_valid = 1'b0;
      r       = 64'hFFFF_FFFF_FFFF_FFFF;
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0 && !valid_out) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", 64'(ok), 64'd1);
  endtask

  // Consumer: deasserts ready_in for stall_len cycles whenever stall_lane is on the output.
  initial begin
    int scnt;
    scnt     = 0;
    ready_in = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_L && valid_out && int'(lane_out) == stall_lane && scnt < stall_len) begin
        ready_in = 1'b0;
        scnt++;
      end else begin
        ready_in = 1'b1;
        if (!(valid_out && int'(lane_out) == stall_lane)) scnt = 0;
      end
    end
  end

  // Monitor: compares every valid slice with the scoreboard head; pops on handshake.
  initial begin
    exp_t e;
    logic exp_rr;
    gap_cnt = 0;
    seen_v  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_L) begin
        sb.delete();
      end else begin
`ifdef ADAPTER_1_TO_4_BACK2BACK_EN
        exp_rr = !valid_out || (last_out && ready_in);
`else
        exp_rr = !valid_out;
`endif
        check("r_ready", 64'(r_ready), 64'(exp_rr));
        if (valid_out) begin
          if (sb.size() == 0) begin
            check("unexpected_slice", 64'(data_out), 64'hDEAD_0000_0000_0000);
          end else begin
            e = sb[0];
            check("data_out", 64'(data_out), 64'(e.data));
            check("lane_out", 64'(lane_out), 64'(e.lane));
            check("last_out", 64'(last_out), 64'(e.last));
            if (ready_in) void'(sb.pop_front());
          end
        end
        if (!in_stream) begin
          seen_v  = 1'b0;
        end else if (valid_out) begin
          seen_v = 1'b1;
        end else if (seen_v && r_valid) begin
          gap_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    r          = '0;
    r_valid    = 1'b0;
    reset_L    = 1'b1;
    stall_lane = -1;
    stall_len  = 0;
    in_stream  = 1'b0;

    vecs[0] = '{word: 64'hCDEF_89AB_4567_0123, exp: {16'hCDEF, 16'h89AB, 16'h4567, 16'h0123},
                stall_lane: -1, stall_len: 0};
    vecs[1] = '{word: 64'hCDEF_89AB_4567_0123, exp: {16'hCDEF, 16'h89AB, 16'h4567, 16'h0123},
                stall_lane: 1, stall_len: 3};
    vecs[2] = '{word: 64'h0123_4567_89AB_CDEF, exp: {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF},
                stall_lane: 0, stall_len: 1};
    vecs[3] = '{word: 64'hFFFF_0000_FFFF_0000, exp: {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000},
                stall_lane: 3, stall_len: 2};
    vecs[4] = '{word: 64'h0000_0000_0000_0000, exp: {16'h0000, 16'h0000, 16'h0000, 16'h0000},
                stall_lane: -1, stall_len: 0};
    vecs[5] = '{word: 64'h8000_0001_7FFF_FFFE, exp: {16'h8000, 16'h0001, 16'h7FFF, 16'hFFFE},
                stall_lane: 2, stall_len: 4};

    // Reset values
    #1 reset_L = 1'b0;
    #2;
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_data_out",  64'(data_out),  64'd0);
    check("rst_lane_out",  64'(lane_out),  64'd0);
    check("rst_last_out",  64'(last_out),  64'd0);
    check("rst_r_ready",   64'(r_ready),   64'd0);
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    #3;
    check("idle_r_ready", 64'(r_ready),   64'd1);
    check("idle_valid",   64'(valid_out), 64'd0);

    // Table of single words with per-lane stalls
    for (int i = 0; i < 6; i++) begin
      stall_lane = vecs[i].stall_lane;
      stall_len  = vecs[i].stall_len;
      send_word(vecs[i].word, vecs[i].exp, 1'b0);
      wait_drain();
    end
    stall_lane = -1;
    stall_len  = 0;

    // Two words with r_valid held high throughout
    in_stream = 1'b1;
    send_word(64'h0123_4567_89AB_CDEF, {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF}, 1'b1);
    send_word(64'h0123_00BB_0AAA_AAAA, {16'h0123, 16'h00BB, 16'h0AAA, 16'hAAAA}, 1'b0);
    wait_drain();
    in_stream = 1'b0;
    check("stream_gap", 64'(gap_cnt), 64'(EXP_GAP));

    // Input word changes while slices are being emitted
    begin
      bit ok;
      ok = 1'b0;
      send_word(64'h1111_2222_3333_4444, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 1'b1);
      @(negedge clk);
      r = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int k = 0; k < 64; k++) begin
        #3;
        if (last_out) begin
          r_valid = 1'b0;
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("last_timeout", 64'(ok), 64'd1);
      wait_drain();
    end

    // Reset asserted during lane 2
    begin
      bit ok;
      ok = 1'b0;
      send_word(64'hA5A5_5A5A_C3C3_3C3C, {16'hA5A5, 16'h5A5A, 16'hC3C3, 16'h3C3C}, 1'b0);
      for (int k = 0; k < 64; k++) begin
        if (valid_out && lane_out == 2'd2) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
        #3;
      end
      check("lane2_timeout", 64'(ok), 64'd1);
      reset_L = 1'b0;
      #1;
      check("mid_rst_valid_out", 64'(valid_out), 64'd0);
      check("mid_rst_data_out",  64'(data_out),  64'd0);
      check("mid_rst_lane_out",  64'(lane_out),  64'd0);
      check("mid_rst_last_out",  64'(last_out),  64'd0);
      check("mid_rst_r_ready",   64'(r_ready),   64'd0);
      repeat (2) @(negedge clk);
      reset_L = 1'b1;
      #3;
      check("post_rst_r_ready", 64'(r_ready),   64'd1);
      check("post_rst_valid",   64'(valid_out), 64'd0);
      send_word(64'h1234_5678_9ABC_DEF0, {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}, 1'b0);
      wait_drain();
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
